// File: rtl/adder_16bit_if.sv
// Operand/result bundle for the IF-stage 16-bit adder.
// The master drives the operands; the slave (the adder) returns the registered sum and flags.
interface adder_16bit_if;
   logic [15:0] op1;
   logic [15:0] op2;
   logic [15:0] result;
   logic        cout;
   logic        overflow;

   modport master (
      output op1,
      output op2,
      input  result,
      input  cout,
      input  overflow
   );

   modport slave (
      input  op1,
      input  op2,
      output result,
      output cout,
      output overflow
   );
endinterface

// File: rtl/adder_16bit.sv
// Registered 16-bit adder for the PC-increment / branch-target path.
// Four 4-bit carry-lookahead groups are chained by a group-level lookahead unit.
module adder_16bit (
   input  logic          clk,
   input  logic          rst,
   adder_16bit_if.slave  bus
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  grp_g;
   logic [3:0]  grp_p;
   logic [4:0]  grp_c;
   logic [15:0] sum;
   logic        carry16;
   logic        ovf;

   assign g = bus.op1 & bus.op2;
   assign p = bus.op1 ^ bus.op2;

   // Group generate/propagate, each group seen as one wide bit by the lookahead unit
   always_comb begin
      grp_g = '0;
      grp_p = '0;
      for (int k = 0; k < 4; k++) begin
         grp_g[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         grp_p[k] = &p[4*k +: 4];
      end
   end

   // Group-level lookahead; carry-in of the whole adder is tied low
   always_comb begin
      grp_c    = '0;
      grp_c[0] = 1'b0;
      grp_c[1] = grp_g[0] | (grp_p[0] & grp_c[0]);
      grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
               | (grp_p[1] & grp_p[0] & grp_c[0]);
      grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
               | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
      grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2])
               | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
   end

   always_comb begin
      c = '0;
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = grp_c[k];
         c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & grp_c[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
      end
   end

   assign sum     = p ^ c;
   assign carry16 = grp_c[4];
   assign ovf     = (bus.op1[15] == bus.op2[15]) && (sum[15] != bus.op1[15]);

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.result   <= 16'd0;
         bus.cout     <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         bus.result   <= sum;
         bus.cout     <= carry16;
         bus.overflow <= ovf;
      end
   end

endmodule

// File: tb/tb_adder_16bit.sv
// Directed and random checks of adder_16bit against an integer-arithmetic reference.
module tb_adder_16bit;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   adder_16bit_if bus();

   adder_16bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] exp_r;
   logic        exp_c;
   logic        exp_o;

   function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic c, output logic o);
      int unsigned u;
      int          s;
      u = 32'(a) + 32'(b);
      r = u[15:0];
      c = u[16];
      s = int'($signed(a)) + int'($signed(b));
      o = (s > 32767) || (s < -32768);
   endfunction

   task automatic check(input string tag);
      n_assert++;
      assert (bus.result === exp_r) else begin
         n_fail++;
         $error("FAIL %s result: got %h expected %h", tag, bus.result, exp_r);
      end
      n_assert++;
      assert (bus.cout === exp_c) else begin
         n_fail++;
         $error("FAIL %s cout: got %b expected %b", tag, bus.cout, exp_c);
      end
      n_assert++;
      assert (bus.overflow === exp_o) else begin
         n_fail++;
         $error("FAIL %s overflow: got %b expected %b", tag, bus.overflow, exp_o);
      end
   endtask

   // Change inputs at the falling edge, confirm outputs hold, then check after the rising edge.
   task automatic apply(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input bit do_hold, input string tag);
      @(negedge clk);
      rst     = r;
      bus.op1 = a;
      bus.op2 = b;
      #1;
      if (do_hold) check({tag, "_hold"});
      if (r) begin
         exp_r = 16'd0;
         exp_c = 1'b0;
         exp_o = 1'b0;
      end else begin
         model(a, b, exp_r, exp_c, exp_o);
      end
      @(posedge clk);
      #1;
      check(tag);
   endtask

   initial begin
      bus.op1 = 16'hFFFF;
      bus.op2 = 16'hFFFF;

      apply(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "reset1");
      apply(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "reset2");
      apply(1'b0, 16'h0000, 16'h0000, 1'b1, "zero");
      apply(1'b0, 16'd10,   16'd20,   1'b1, "ten_twenty");
      apply(1'b0, 16'hFFFF, 16'h0001, 1'b1, "wrap");
      apply(1'b0, 16'h7FFF, 16'h0001, 1'b1, "pos_ovf");
      apply(1'b0, 16'h8000, 16'h8000, 1'b1, "neg_ovf");
      apply(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, "all_ones");
      apply(1'b0, 16'h0FFF, 16'h0001, 1'b1, "grp_ripple");

      for (int i = 0; i < 10; i++) begin
         apply(i == 5, 16'($urandom), 16'($urandom), 1'b1, "stream");
      end

      for (int i = 0; i < 300; i++) begin
         apply(1'b0, 16'($urandom), 16'($urandom), 1'b1, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
